// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM state, return-owner tags and default bus widths.
package sram_port_arbiter_pkg;

   typedef enum logic {
      ARB_ST_IDLE  = 1'b0,
      ARB_ST_DEFER = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      ARB_OWNER_NONE = 2'd0,
      ARB_OWNER_INST = 2'd1,
      ARB_OWNER_DATA = 2'd2
   } arb_owner_e;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/arb_req_buf.sv
// Pending fetch register {wen, addr, wdata}; load captures, clr/rst zero it.
// One-cycle capture latency; clear takes priority over load.
module arb_req_buf #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int WEN_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [WEN_W-1:0]  ld_wen,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic [WEN_W-1:0]  buf_wen,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_wdata
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         buf_wen   <= '0;
         buf_addr  <= '0;
         buf_wdata <= '0;
      end else if (load) begin
         buf_wen   <= ld_wen;
         buf_addr  <= ld_addr;
         buf_wdata <= ld_wdata;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency SRAM between fetch and data ports; data always wins, a colliding fetch
// is deferred and replayed while stallreq freezes IF/ID. Optional ARB_PERF_CNT_EN adds conflict_cnt.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W,
   parameter int WEN_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_en,
   input  logic [WEN_W-1:0]  inst_wen,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_rvalid,
   input  logic              data_en,
   input  logic [WEN_W-1:0]  data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_rvalid,
   output logic              stallreq,
   output logic              mem_en,
   output logic [WEN_W-1:0]  mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       conflict_cnt
`endif
);

   arb_state_e        state, state_nxt;
   arb_owner_e        owner;
   logic [DATA_W-1:0] inst_hold;
   logic              sel_data, sel_pend, sel_inst;
   logic              pend_load, pend_clr;
   logic [WEN_W-1:0]  pend_wen;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_wdata;
   logic              issue_read;

   arb_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEN_W(WEN_W)) u_req_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (pend_load),
      .clr       (pend_clr),
      .ld_wen    (inst_wen),
      .ld_addr   (inst_addr),
      .ld_wdata  (inst_wdata),
      .buf_wen   (pend_wen),
      .buf_addr  (pend_addr),
      .buf_wdata (pend_wdata)
   );

   // Data only forces a deferral when a fetch actually collides with it.
   always_comb begin
      sel_data  = 1'b0;
      sel_pend  = 1'b0;
      sel_inst  = 1'b0;
      pend_load = 1'b0;
      pend_clr  = 1'b0;
      stallreq  = 1'b0;
      state_nxt = state;
      if (!rst) begin
         unique case (state)
            ARB_ST_IDLE: begin
               if (data_en) begin
                  sel_data = 1'b1;
                  if (inst_en) begin
                     pend_load = 1'b1;
                     stallreq  = 1'b1;
                     state_nxt = ARB_ST_DEFER;
                  end
               end else if (inst_en) begin
                  sel_inst = 1'b1;
               end
            end
            ARB_ST_DEFER: begin
               if (data_en) begin
                  sel_data = 1'b1;
                  stallreq = 1'b1;
               end else begin
                  sel_pend  = 1'b1;
                  pend_clr  = 1'b1;
                  state_nxt = ARB_ST_IDLE;
               end
            end
            default: state_nxt = ARB_ST_IDLE;
         endcase
      end
   end

   assign mem_en    = sel_data | sel_pend | sel_inst;
   assign mem_wen   = sel_data ? data_wen   : sel_pend ? pend_wen   : sel_inst ? inst_wen   : '0;
   assign mem_addr  = sel_data ? data_addr  : sel_pend ? pend_addr  : sel_inst ? inst_addr  : '0;
   assign mem_wdata = sel_data ? data_wdata : sel_pend ? pend_wdata : sel_inst ? inst_wdata : '0;
   assign issue_read = mem_en && (mem_wen == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_ST_IDLE;
         owner     <= ARB_OWNER_NONE;
         inst_hold <= '0;
      end else begin
         state <= state_nxt;
         owner <= !issue_read ? ARB_OWNER_NONE : (sel_data ? ARB_OWNER_DATA : ARB_OWNER_INST);
         if (inst_rvalid) inst_hold <= mem_rdata;
      end
   end

   assign inst_rvalid = !rst && (owner == ARB_OWNER_INST);
   assign data_rvalid = !rst && (owner == ARB_OWNER_DATA);
   // Fetch data stays frozen at the last returned word while IF/ID is stalled.
   assign inst_rdata  = rst ? '0 : (inst_rvalid ? mem_rdata : inst_hold);
   assign data_rdata  = data_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] cnt_q;
   always_ff @(posedge clk) begin
      if (rst)                               cnt_q <= '0;
      else if (stallreq && (cnt_q != '1))    cnt_q <= cnt_q + 32'd1;
   end
   assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, multi-cycle sequences and a randomized
// run checked against a request-level reference model.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_en, data_en;
   logic [3:0]  inst_wen, data_wen;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        inst_rvalid, data_rvalid, stallreq, mem_en;
   logic [3:0]  mem_wen;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] conflict_cnt;
`endif

   always #5 clk = ~clk;

   sram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_en(inst_en), .inst_wen(inst_wen), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
      .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_rvalid(data_rvalid),
      .stallreq(stallreq),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: at most one deferred fetch, and which port (if any) a read returns to next cycle.
   bit          m_def;
   logic [3:0]  m_pwen;
   logic [31:0] m_paddr, m_pwdata, m_hold, m_cnt;
   int          m_ret;        // 0 nobody, 1 fetch port, 2 data port
   logic        e_en, e_stall, e_irv, e_drv;
   logic [3:0]  e_wen;
   logic [31:0] e_addr, e_wdata, e_ir, e_dr;
   int          e_src;

   task automatic model_eval();
      e_en = 0; e_wen = 0; e_addr = 0; e_wdata = 0; e_stall = 0; e_src = 0;
      if (!rst) begin
         if (data_en) begin
            e_en = 1; e_wen = data_wen; e_addr = data_addr; e_wdata = data_wdata; e_src = 2;
            e_stall = m_def || inst_en;
         end else if (m_def) begin
            e_en = 1; e_wen = m_pwen; e_addr = m_paddr; e_wdata = m_pwdata; e_src = 1;
         end else if (inst_en) begin
            e_en = 1; e_wen = inst_wen; e_addr = inst_addr; e_wdata = inst_wdata; e_src = 1;
         end
      end
      e_irv = !rst && (m_ret == 1);
      e_drv = !rst && (m_ret == 2);
      e_ir  = rst ? 32'h0 : (e_irv ? mem_rdata : m_hold);
      e_dr  = e_drv ? mem_rdata : 32'h0;
   endtask

   task automatic model_update();
      if (rst) begin
         m_def = 0; m_ret = 0; m_hold = 0; m_cnt = 0;
         m_pwen = 0; m_paddr = 0; m_pwdata = 0;
      end else begin
         if (e_irv) m_hold = mem_rdata;
         m_ret = (e_en && e_wen == 4'h0) ? e_src : 0;
         if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (data_en && inst_en && !m_def) begin
            m_def = 1; m_pwen = inst_wen; m_paddr = inst_addr; m_pwdata = inst_wdata;
         end else if (!data_en && m_def) begin
            m_def = 0;
         end
      end
   endtask

   task automatic model_check();
      chk("mem_en", mem_en, e_en);
      if (e_en) begin
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wen", mem_wen, e_wen);
         chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("stallreq", stallreq, e_stall);
      chk("inst_rvalid", inst_rvalid, e_irv);
      chk("data_rvalid", data_rvalid, e_drv);
      chk("inst_rdata", inst_rdata, e_ir);
      chk("data_rdata", data_rdata, e_dr);
`ifdef ARB_PERF_CNT_EN
      chk("conflict_cnt", conflict_cnt, m_cnt);
`endif
   endtask

   // One modelled clock: inputs already applied; compare at negedge, then advance past posedge.
   task automatic model_cycle();
      @(negedge clk);
      model_eval();
      model_check();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic ie, input logic [31:0] ia,
                        input logic de, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] mr);
      rst = r; inst_en = ie; inst_wen = 4'h0; inst_addr = ia; inst_wdata = 32'h0;
      data_en = de; data_wen = dw; data_addr = da; data_wdata = 32'hA5A5_0000 ^ da; mem_rdata = mr;
   endtask

   typedef struct {
      logic        rst, ie, de;
      logic [31:0] ia, da, mr;
      logic [3:0]  dw;
      logic        x_en, x_stall, x_irv, x_drv;
      logic [31:0] x_addr, x_ir, x_dr;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic ie, input logic [31:0] ia,
                               input logic de, input logic [3:0] dw, input logic [31:0] da,
                               input logic [31:0] mr, input logic xe, input logic [31:0] xa,
                               input logic xs, input logic xirv, input logic xdrv,
                               input logic [31:0] xir, input logic [31:0] xdr);
      vec_t v;
      v.rst = r; v.ie = ie; v.ia = ia; v.de = de; v.dw = dw; v.da = da; v.mr = mr;
      v.x_en = xe; v.x_addr = xa; v.x_stall = xs; v.x_irv = xirv; v.x_drv = xdrv;
      v.x_ir = xir; v.x_dr = xdr;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      // rst  ie  inst_addr      de  wen   data_addr      mem_rdata      en  mem_addr      st irv drv inst_rdata     data_rdata
      tbl[0]  = mk(1, 1, 32'hBFC0_0000, 1, 4'h0, 32'h8000_0000, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0,         32'h0);
      tbl[1]  = mk(0, 1, 32'hBFC0_0000, 0, 4'h0, 32'h0,         32'h0,         1, 32'hBFC0_0000, 0, 0, 0, 32'h0,         32'h0);
      tbl[2]  = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h1111_1111, 0, 32'h0,         0, 1, 0, 32'h1111_1111, 32'h0);
      tbl[3]  = mk(0, 1, 32'hBFC0_0010, 1, 4'h0, 32'h8000_1000, 32'hDEAD_0003, 1, 32'h8000_1000, 1, 0, 0, 32'h1111_1111, 32'h0);
      tbl[4]  = mk(0, 1, 32'h1234_5678, 0, 4'h0, 32'h0,         32'h2222_2222, 1, 32'hBFC0_0010, 0, 0, 1, 32'h1111_1111, 32'h2222_2222);
      tbl[5]  = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h3333_3333, 0, 32'h0,         0, 1, 0, 32'h3333_3333, 32'h0);
      tbl[6]  = mk(0, 1, 32'hBFC0_0020, 1, 4'hF, 32'h8000_2000, 32'h0,         1, 32'h8000_2000, 1, 0, 0, 32'h3333_3333, 32'h0);
      tbl[7]  = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0BAD_0007, 1, 32'hBFC0_0020, 0, 0, 0, 32'h3333_3333, 32'h0);
      tbl[8]  = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h4444_4444, 0, 32'h0,         0, 1, 0, 32'h4444_4444, 32'h0);
      tbl[9]  = mk(0, 1, 32'hBFC0_0030, 1, 4'h0, 32'h8000_3000, 32'h0,         1, 32'h8000_3000, 1, 0, 0, 32'h4444_4444, 32'h0);
      tbl[10] = mk(0, 0, 32'h0,         1, 4'h0, 32'h8000_3004, 32'h5555_5555, 1, 32'h8000_3004, 1, 0, 1, 32'h4444_4444, 32'h5555_5555);
      tbl[11] = mk(0, 0, 32'h0,         1, 4'h0, 32'h8000_3008, 32'h6666_6666, 1, 32'h8000_3008, 1, 0, 1, 32'h4444_4444, 32'h6666_6666);
      tbl[12] = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h7777_7777, 1, 32'hBFC0_0030, 0, 0, 1, 32'h4444_4444, 32'h7777_7777);
      tbl[13] = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'h8888_8888, 0, 32'h0,         0, 1, 0, 32'h8888_8888, 32'h0);
      tbl[14] = mk(0, 1, 32'hBFC0_0040, 1, 4'h0, 32'h8000_4000, 32'h0,         1, 32'h8000_4000, 1, 0, 0, 32'h8888_8888, 32'h0);
      tbl[15] = mk(1, 0, 32'h0,         0, 4'h0, 32'h0,         32'h9999_9999, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0);
      tbl[16] = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'hAAAA_AAAA, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0);
      tbl[17] = mk(0, 0, 32'h0,         0, 4'h0, 32'h0,         32'hBBBB_BBBB, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0);

      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      // Directed table: fetch-only, read collision, write collision, long stall, reset in DEFER.
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rst, tbl[i].ie, tbl[i].ia, tbl[i].de, tbl[i].dw, tbl[i].da, tbl[i].mr);
         @(negedge clk);
         chk($sformatf("row%0d mem_en", i), mem_en, tbl[i].x_en);
         if (tbl[i].x_en) chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].x_addr);
         chk($sformatf("row%0d stallreq", i), stallreq, tbl[i].x_stall);
         chk($sformatf("row%0d inst_rvalid", i), inst_rvalid, tbl[i].x_irv);
         chk($sformatf("row%0d data_rvalid", i), data_rvalid, tbl[i].x_drv);
         chk($sformatf("row%0d inst_rdata", i), inst_rdata, tbl[i].x_ir);
         chk($sformatf("row%0d data_rdata", i), data_rdata, tbl[i].x_dr);
         model_eval();
         model_update();
         @(posedge clk);
         #1;
      end

      // Two isolated collisions after a reset.
      drive(1, 0, 0, 0, 0, 0, 0);                                   model_cycle();
      drive(0, 1, 32'hBFC0_0100, 1, 4'h0, 32'h8000_0100, 32'h0);    model_cycle();
      drive(0, 0, 0, 0, 0, 0, 32'h1);                               model_cycle();
      drive(0, 0, 0, 0, 0, 0, 32'h2);                               model_cycle();
      drive(0, 1, 32'hBFC0_0200, 1, 4'h3, 32'h8000_0200, 32'h0);    model_cycle();
      drive(0, 0, 0, 0, 0, 0, 32'h3);                               model_cycle();
      drive(0, 0, 0, 0, 0, 0, 32'h4);
      @(negedge clk);
`ifdef ARB_PERF_CNT_EN
      chk("conflict_cnt two collisions", conflict_cnt, 32'd2);
`endif
      chk("stallreq after collisions", stallreq, 1'b0);
      model_eval();
      model_update();
      @(posedge clk);
      #1;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(40) == 0);
         inst_en    = $urandom_range(1);
         inst_wen   = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
         inst_addr  = $urandom;
         inst_wdata = $urandom;
         data_en    = ($urandom_range(2) == 0);
         data_wen   = $urandom_range(1) ? 4'($urandom) : 4'h0;
         data_addr  = $urandom;
         data_wdata = $urandom;
         mem_rdata  = $urandom;
         model_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
